br_pred_bht: RTL and testbench

- Parametrised successor to the static branch predictor in the decode stage.
- Replaces the "forward offset ⇒ taken" heuristic with a PC-indexed table of saturating counters (BHT).
- Resolves each prediction one cycle later with correct-path redirect, trains the counters, and exposes prediction/misprediction statistics.
- Sits between IF/ID and the PC mux; one branch is in flight at a time.

---
 rtl/br_pred_bht.sv | 81 ++++++++
 tb/tb_br_pred_bht.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/br_pred_bht.sv
// br_pred_bht: PC-indexed saturating-counter branch predictor with a one-cycle resolve,
// correct-path redirect, counter training and saturating prediction/misprediction statistics.
module br_pred_bht #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_W       = 2,
  parameter int INIT_CTR    = 1,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              predreq,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] offset,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] s1data_n,
  input  logic [DATA_W-1:0] s2data_n,
  output logic              brpred_o,
  output logic [ADDR_W-1:0] btpred_o,
  output logic              mispred_o,
  output logic [ADDR_W-1:0] redirect_o,
  output logic [STAT_W-1:0] pred_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  logic [CTR_W-1:0] ctr [BHT_ENTRIES];
  logic pend_v, pend_taken;
  logic [ADDR_W-1:0] pend_pc;
  logic [DATA_W-1:0] pend_off;
  logic [2:0] pend_f3;
  logic [IDX_W-1:0] pend_idx, idx;
  logic resolve, legal, cmp, actual, predict;
  logic [CTR_W-1:0] pend_ctr;
  function automatic logic [ADDR_W-1:0] tgt(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] off);
    return base + ADDR_W'($signed(off));
  endfunction
  assign idx = pc[IDX_W+1:2];
  assign pend_ctr = ctr[pend_idx];
  assign resolve = pend_v & ~stall;
  assign legal = pend_f3[2:1] != 2'b01;
  // odd encodings (bne/bge/bgeu) are the inverse of their even partner's test
  assign cmp = pend_f3[2] ? (pend_f3[1] ? s1data_n < s2data_n : $signed(s1data_n) < $signed(s2data_n))
                          : s1data_n == s2data_n;
  assign actual = cmp ^ pend_f3[0];
  assign mispred_o = resolve & legal & (actual != pend_taken);
  assign redirect_o = mispred_o ? (actual ? tgt(pend_pc, pend_off) : pend_pc + ADDR_W'(4)) : '0;
  assign predict = predreq & ~stall & ~mispred_o;
  assign brpred_o = predict & ctr[idx][CTR_W-1];
  assign btpred_o = brpred_o ? tgt(pc, offset) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= CTR_W'(INIT_CTR);
      pend_v        <= 1'b0;
      pend_taken    <= 1'b0;
      pend_pc       <= '0;
      pend_off      <= '0;
      pend_f3       <= '0;
      pend_idx      <= '0;
      pred_cnt_o    <= '0;
      mispred_cnt_o <= '0;
    end else if (!stall) begin
      pend_v <= predict;
      if (predict) begin
        pend_pc    <= pc;
        pend_off   <= offset;
        pend_f3    <= funct3;
        pend_idx   <= idx;
        pend_taken <= ctr[idx][CTR_W-1];
      end
      if (resolve && legal)
        ctr[pend_idx] <= actual ? (pend_ctr == CTR_MAX ? pend_ctr : pend_ctr + CTR_W'(1))
                                : (pend_ctr == '0 ? pend_ctr : pend_ctr - CTR_W'(1));
      if (predict && pred_cnt_o != STAT_MAX) pred_cnt_o <= pred_cnt_o + STAT_W'(1);
      if (mispred_o && mispred_cnt_o != STAT_MAX) mispred_cnt_o <= mispred_cnt_o + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_br_pred_bht.sv
// tb_br_pred_bht: directed plus randomized check of br_pred_bht against a behavioural model
// of the counter table, the in-flight branch and the saturating statistics.
module tb_br_pred_bht;
  localparam int ENT = 4;
  localparam int SMAX = 255;
  logic clk = 0, rst = 1, stall = 0, predreq = 0;
  logic [31:0] pc = 0, offset = 0, s1 = 0, s2 = 0;
  logic [2:0] funct3 = 0;
  logic brpred_o, mispred_o;
  logic [31:0] btpred_o, redirect_o;
  logic [7:0] pred_cnt_o, mispred_cnt_o;
  int n_chk = 0, n_err = 0;
  br_pred_bht #(.BHT_ENTRIES(ENT), .STAT_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .predreq(predreq), .pc(pc), .offset(offset),
    .funct3(funct3), .s1data_n(s1), .s2data_n(s2), .brpred_o(brpred_o), .btpred_o(btpred_o),
    .mispred_o(mispred_o), .redirect_o(redirect_o), .pred_cnt_o(pred_cnt_o),
    .mispred_cnt_o(mispred_cnt_o));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  function automatic logic outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  // behavioural model: table of small integers, one in-flight branch record, integer statistics
  int m_bht [ENT];
  int m_pcn, m_mcn, cur, m_idx;
  logic m_v, m_tk, res, leg, act, e_mis, e_pred, e_br;
  logic [31:0] m_pc, m_off, e_red, e_bt;
  logic [2:0] m_f3;
  always @(negedge clk) begin
    if (rst) begin
      m_v = 0; m_pcn = 0; m_mcn = 0;
      for (int i = 0; i < ENT; i++) m_bht[i] = 1;
      res = 0; leg = 0; act = 0; e_mis = 0; e_red = 0; e_pred = 0; e_br = 0; e_bt = 0; cur = 0;
    end else begin
      res = m_v && !stall;
      leg = !(m_f3 == 3'd2 || m_f3 == 3'd3);
      act = outcome(m_f3, s1, s2);
      e_mis = res && leg && (act != m_tk);
      e_red = e_mis ? (act ? m_pc + m_off : m_pc + 4) : 0;
      e_pred = predreq && !stall && !e_mis;
      cur = m_bht[int'((pc >> 2) % ENT)];
      e_br = e_pred && cur >= 2;
      e_bt = e_br ? pc + offset : 0;
    end
    chk("brpred", {31'b0, brpred_o}, {31'b0, e_br});
    chk("btpred", btpred_o, e_bt);
    chk("mispred", {31'b0, mispred_o}, {31'b0, e_mis});
    chk("redirect", redirect_o, e_red);
    chk("pred_cnt", {24'b0, pred_cnt_o}, m_pcn);
    chk("mispred_cnt", {24'b0, mispred_cnt_o}, m_mcn);
    if (!rst && !stall) begin
      if (res && leg) m_bht[m_idx] = act ? (m_bht[m_idx] < 3 ? m_bht[m_idx] + 1 : 3)
                                         : (m_bht[m_idx] > 0 ? m_bht[m_idx] - 1 : 0);
      if (e_pred && m_pcn < SMAX) m_pcn++;
      if (e_mis && m_mcn < SMAX) m_mcn++;
      m_v = e_pred;
      if (e_pred) begin
        m_pc = pc; m_off = offset; m_f3 = funct3; m_tk = cur >= 2;
        m_idx = int'((pc >> 2) % ENT);
      end
    end
  end
  task automatic drv(input logic pr, input logic [31:0] p, input logic [31:0] o, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] b, input logic st);
    predreq = pr; pc = p; offset = o; funct3 = f; s1 = a; s2 = b; stall = st;
  endtask
  task automatic nxt;
    @(posedge clk); #1;
  endtask
  function automatic logic [31:0] pick;
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst brpred", {31'b0, brpred_o}, 0);
    chk("rst mispred", {31'b0, mispred_o}, 0);
    chk("rst pred_cnt", {24'b0, pred_cnt_o}, 0);
    nxt();
    drv(1, 32'h100, 32'h40, 3'd0, 0, 0, 0);
    @(negedge clk); chk("A brpred", {31'b0, brpred_o}, 0); chk("A btpred", btpred_o, 0);
    nxt();
    drv(1, 32'h200, 32'h40, 3'd0, 5, 5, 0);
    @(negedge clk); chk("B mispred", {31'b0, mispred_o}, 1); chk("B redirect", redirect_o, 32'h140);
    chk("B squash", {31'b0, brpred_o}, 0);
    nxt();
    drv(1, 32'h100, 32'h40, 3'd0, 0, 0, 0);
    @(negedge clk); chk("C brpred", {31'b0, brpred_o}, 1); chk("C btpred", btpred_o, 32'h140);
    chk("C pred_cnt", {24'b0, pred_cnt_o}, 1);
    nxt();
    drv(0, 0, 0, 3'd0, 7, 7, 0);
    @(negedge clk); chk("D mispred", {31'b0, mispred_o}, 0);
    chk("D mispred_cnt", {24'b0, mispred_cnt_o}, 1);
    nxt();
    drv(1, 32'h100, 32'h40, 3'd1, 0, 0, 0);
    @(negedge clk); chk("E brpred", {31'b0, brpred_o}, 1);
    nxt();
    drv(0, 0, 0, 3'd0, 9, 9, 0);
    @(negedge clk); chk("F mispred", {31'b0, mispred_o}, 1); chk("F redirect", redirect_o, 32'h104);
    nxt();
    drv(1, 32'h100, 32'h40, 3'd1, 0, 0, 0);
    @(negedge clk); chk("G brpred", {31'b0, brpred_o}, 1);
    nxt();
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h100, 32'h40, 3'd1, 9, 9, 1);
      @(negedge clk); chk("H stall mispred", {31'b0, mispred_o}, 0);
      chk("H stall brpred", {31'b0, brpred_o}, 0); chk("H stall redirect", redirect_o, 0);
      nxt();
    end
    drv(0, 0, 0, 3'd0, 9, 9, 0);
    @(negedge clk); chk("I mispred", {31'b0, mispred_o}, 1); chk("I redirect", redirect_o, 32'h104);
    nxt();
    drv(1, 32'h100, 32'h40, 3'd4, 0, 0, 0);
    @(negedge clk); chk("J brpred", {31'b0, brpred_o}, 0);
    nxt();
    drv(0, 0, 0, 3'd0, 32'hFFFF_FFFF, 1, 0);
    @(negedge clk); chk("K blt mispred", {31'b0, mispred_o}, 1); chk("K redirect", redirect_o, 32'h140);
    nxt();
    drv(1, 32'h100, 32'h40, 3'd6, 0, 0, 0);
    @(negedge clk); chk("L brpred", {31'b0, brpred_o}, 1);
    nxt();
    drv(0, 0, 0, 3'd0, 32'hFFFF_FFFF, 1, 0);
    @(negedge clk); chk("M bltu mispred", {31'b0, mispred_o}, 1); chk("M redirect", redirect_o, 32'h104);
    nxt();
    drv(1, 32'h10, 32'h40, 3'd0, 0, 0, 0);
    @(negedge clk); chk("N brpred", {31'b0, brpred_o}, 0);
    nxt();
    drv(0, 0, 0, 3'd0, 3, 3, 0);
    @(negedge clk); chk("O redirect", redirect_o, 32'h50);
    nxt();
    drv(1, 32'h20, 32'h40, 3'd0, 0, 0, 0);
    @(negedge clk); chk("P alias brpred", {31'b0, brpred_o}, 1); chk("P btpred", btpred_o, 32'h60);
    nxt();
    drv(0, 0, 0, 3'd0, 1, 2, 0); rst = 1;
    @(negedge clk); chk("Q rst mispred", {31'b0, mispred_o}, 0);
    chk("Q rst pred_cnt", {24'b0, pred_cnt_o}, 0);
    nxt();
    rst = 0; drv(1, 32'h20, 32'h40, 3'd0, 0, 0, 0);
    @(negedge clk); chk("R brpred", {31'b0, brpred_o}, 0);
    nxt();
    for (int k = 0; k < 3000; k++) begin
      int t;
      t = int'($urandom_range(0, 255)) - 128;
      rst = $urandom_range(0, 599) == 0;
      stall = $urandom_range(0, 9) == 0;
      predreq = $urandom_range(0, 9) < 6;
      pc = ($urandom_range(0, 63) << 2) | ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0);
      offset = $urandom_range(0, 1) ? 32'(t * 4) : $urandom();
      funct3 = 3'($urandom_range(0, 7));
      s1 = pick();
      s2 = $urandom_range(0, 1) ? s1 : pick();
      nxt();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
